// File: rtl/rcv_block_fifo_pkg.sv
// -----------------------------------------------------------------------------
// rcv_fifo_pkg
// Purpose : shared defaults and helpers for the receive block FIFO.
//           - default word width, words per entry and entry depth
//           - incr_wrap(): pointer increment that wraps by explicit compare,
//             so the FIFO works for depths that are not a power of two
// Ports   : none (package)
// -----------------------------------------------------------------------------
package rcv_fifo_pkg;

  localparam int WORD_W_DEF          = 32;
  localparam int WORDS_PER_ENTRY_DEF = 4;
  localparam int DEPTH_DEF           = 3;

  // Returns 0 when v has reached last, otherwise v+1.
  function automatic int unsigned incr_wrap(input int unsigned v,
                                            input int unsigned last);
    return (v == last) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/rcv_block_fifo_if.sv
// -----------------------------------------------------------------------------
// rcv_block_fifo_if
// Purpose : bundles the write, control and read signals of rcv_block_fifo.
// Signals : HWDATA     write word
//           WE         write strobe, one word per asserted cycle
//           flush      abandon the partially assembled entry
//           clear_err  clear the sticky overflow flag
//           rd_ready   consumer accepts the head entry
//           rd_valid   head entry valid
//           rd_data    head entry, word 0 in the MSBs
//           count      committed entries
//           full/empty occupancy flags
//           overflow   sticky: a word was dropped
// Modports: master = producer/consumer side, slave = the FIFO.
// -----------------------------------------------------------------------------
interface rcv_block_fifo_if #(
  parameter int WORD_W          = rcv_fifo_pkg::WORD_W_DEF,
  parameter int WORDS_PER_ENTRY = rcv_fifo_pkg::WORDS_PER_ENTRY_DEF,
  parameter int DEPTH           = rcv_fifo_pkg::DEPTH_DEF
) ();

  localparam int ENTRY_W = WORD_W * WORDS_PER_ENTRY;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [WORD_W-1:0]  HWDATA;
  logic               WE;
  logic               flush;
  logic               clear_err;
  logic               rd_ready;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               overflow;

  modport master (
    output HWDATA, WE, flush, clear_err, rd_ready,
    input  rd_valid, rd_data, count, full, empty, overflow
  );

  modport slave (
    input  HWDATA, WE, flush, clear_err, rd_ready,
    output rd_valid, rd_data, count, full, empty, overflow
  );

endinterface

// File: rtl/rcv_block_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// rcv_block_fifo_ctrl
// Purpose : pointer / occupancy / error bookkeeping for rcv_block_fifo.
// Ports   : clk, n_rst      clock, synchronous active-low reset
//           we_i, flush_i   write strobe and partial-entry flush
//           clear_err_i     clear sticky overflow
//           rd_ready_i      consumer ready
//           wr_en_o         this cycle's word is stored
//           wr_ptr_o        entry slot being assembled (tail)
//           wr_idx_o        word position inside that entry
//           rd_ptr_o        head entry slot
//           pop_o           head entry is consumed this cycle
//           count_o, full_o, empty_o, rd_valid_o, overflow_o  status
// -----------------------------------------------------------------------------
module rcv_block_fifo_ctrl
  import rcv_fifo_pkg::*;
#(
  parameter int WORDS_PER_ENTRY = WORDS_PER_ENTRY_DEF,
  parameter int DEPTH           = DEPTH_DEF,
  parameter int PTR_W           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int IDX_W           = (WORDS_PER_ENTRY > 1) ? $clog2(WORDS_PER_ENTRY) : 1,
  parameter int CNT_W           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             we_i,
  input  logic             flush_i,
  input  logic             clear_err_i,
  input  logic             rd_ready_i,
  output logic             wr_en_o,
  output logic [PTR_W-1:0] wr_ptr_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic             pop_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             rd_valid_o,
  output logic             overflow_o
);

  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic full, empty, accept, commit, pop, drop;

  // Flags come only from registered count, so rd_ready never reaches
  // rd_valid/full/count combinationally.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // full is judged before any same-cycle pop, so a word arriving while
  // full is dropped even if a slot frees up on this edge.
  assign accept = we_i && !full && !flush_i;
  assign commit = accept && (word_idx_q == IDX_W'(WORDS_PER_ENTRY - 1));
  assign pop    = !empty && rd_ready_i;
  // A flushed word is discarded on purpose and is not an overflow.
  assign drop   = we_i && full && !flush_i;

  always_comb begin
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush_i) begin
      word_idx_d = '0;
    end else if (accept) begin
      word_idx_d = IDX_W'(incr_wrap(32'(word_idx_q), 32'(WORDS_PER_ENTRY - 1)));
    end

    if (commit) begin
      tail_ptr_d = PTR_W'(incr_wrap(32'(tail_ptr_q), 32'(DEPTH - 1)));
    end

    if (pop) begin
      head_ptr_d = PTR_W'(incr_wrap(32'(head_ptr_q), 32'(DEPTH - 1)));
    end

    unique case ({commit, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new drop outranks a clear in the same cycle.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_err_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en_o    = accept;
  assign wr_ptr_o   = tail_ptr_q;
  assign wr_idx_o   = word_idx_q;
  assign rd_ptr_o   = head_ptr_q;
  assign pop_o      = pop;
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign rd_valid_o = !empty;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/rcv_block_fifo.sv
// -----------------------------------------------------------------------------
// rcv_block_fifo
// Purpose : receive FIFO between the AHB slave write path and the block
//           processing core. Gathers WORDS_PER_ENTRY bus words into one wide
//           entry, stores up to DEPTH entries and presents the oldest one on
//           a valid/ready read port.
// Ports   : clk    system clock (posedge)
//           n_rst  synchronous active-low reset
//           bus    rcv_block_fifo_if.slave: HWDATA/WE/flush/clear_err/rd_ready
//                  in; rd_valid/rd_data/count/full/empty/overflow out
// -----------------------------------------------------------------------------
module rcv_block_fifo
  import rcv_fifo_pkg::*;
#(
  parameter int WORD_W          = WORD_W_DEF,
  parameter int WORDS_PER_ENTRY = WORDS_PER_ENTRY_DEF,
  parameter int DEPTH           = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  rcv_block_fifo_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (WORDS_PER_ENTRY > 1) ? $clog2(WORDS_PER_ENTRY) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [IDX_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;
  logic [CNT_W-1:0] count;
  logic             full, empty, rd_valid, overflow;

  rcv_block_fifo_ctrl #(
    .WORDS_PER_ENTRY (WORDS_PER_ENTRY),
    .DEPTH           (DEPTH),
    .PTR_W           (PTR_W),
    .IDX_W           (IDX_W),
    .CNT_W           (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .n_rst       (n_rst),
    .we_i        (bus.WE),
    .flush_i     (bus.flush),
    .clear_err_i (bus.clear_err),
    .rd_ready_i  (bus.rd_ready),
    .wr_en_o     (wr_en),
    .wr_ptr_o    (wr_ptr),
    .wr_idx_o    (wr_idx),
    .rd_ptr_o    (rd_ptr),
    .pop_o       (pop),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty),
    .rd_valid_o  (rd_valid),
    .overflow_o  (overflow)
  );

  // One storage lane per word position; lane gi holds word gi of every entry.
  // Word 0 lands in the MSBs of rd_data. The head entry is read
  // combinationally and zeroed while empty so stale data never leaks out.
  // Storage is deliberately not reset.
  generate
    for (genvar gi = 0; gi < WORDS_PER_ENTRY; gi++) begin : g_lane
      logic [WORD_W-1:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en && (wr_idx == IDX_W'(gi))) begin
          lane_mem[wr_ptr] <= bus.HWDATA;
        end
      end

      assign bus.rd_data[(WORDS_PER_ENTRY-1-gi)*WORD_W +: WORD_W] =
        empty ? '0 : lane_mem[rd_ptr];
    end
  endgenerate

  assign bus.rd_valid = rd_valid;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow;

endmodule

// File: tb/tb_rcv_block_fifo.sv
// -----------------------------------------------------------------------------
// tb_rcv_block_fifo
// Directed bench: one instance with default parameters (DEPTH=3) and one with
// DEPTH=5 for the long streaming / pointer-wrap case.
// -----------------------------------------------------------------------------
module tb_rcv_block_fifo;

  logic clk = 1'b0;
  logic n_rst_a;
  logic n_rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rcv_block_fifo_if #(.WORD_W(32), .WORDS_PER_ENTRY(4), .DEPTH(3)) a_if ();
  rcv_block_fifo_if #(.WORD_W(32), .WORDS_PER_ENTRY(4), .DEPTH(5)) b_if ();

  rcv_block_fifo #(.WORD_W(32), .WORDS_PER_ENTRY(4), .DEPTH(3)) dut_a (
    .clk   (clk),
    .n_rst (n_rst_a),
    .bus   (a_if)
  );

  rcv_block_fifo #(.WORD_W(32), .WORDS_PER_ENTRY(4), .DEPTH(5)) dut_b (
    .clk   (clk),
    .n_rst (n_rst_b),
    .bus   (b_if)
  );

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ent(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2, input logic [31:0] w3);
    return {w0, w1, w2, w3};
  endfunction

  // Entry built from base: words base, base+1, base+2, base+3.
  function automatic logic [127:0] ent_seq(input logic [31:0] base);
    return ent(base, base + 32'd1, base + 32'd2, base + 32'd3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wa(input logic [31:0] d);
    a_if.HWDATA = d;
    a_if.WE     = 1'b1;
    tick();
    a_if.WE     = 1'b0;
  endtask

  task automatic pop_a();
    a_if.rd_ready = 1'b1;
    tick();
    a_if.rd_ready = 1'b0;
  endtask

  initial begin
    a_if.HWDATA = '0; a_if.WE = 0; a_if.flush = 0; a_if.clear_err = 0; a_if.rd_ready = 0;
    b_if.HWDATA = '0; b_if.WE = 0; b_if.flush = 0; b_if.clear_err = 0; b_if.rd_ready = 0;
    n_rst_a = 1'b0;
    n_rst_b = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count",    a_if.count,    0);
    check("rst_empty",    a_if.empty,    1);
    check("rst_full",     a_if.full,     0);
    check("rst_rd_valid", a_if.rd_valid, 0);
    check("rst_overflow", a_if.overflow, 0);
    check("rst_rd_data",  a_if.rd_data,  0);
    check("rst_b_empty",  b_if.empty,    1);
    n_rst_a = 1'b1;
    n_rst_b = 1'b1;

    // One entry A0..A3
    wa(32'hA0); wa(32'hA1); wa(32'hA2);
    check("a3_not_yet_valid", a_if.rd_valid, 0);
    wa(32'hA3);
    check("a_rd_valid", a_if.rd_valid, 1);
    check("a_count",    a_if.count,    1);
    check("a_rd_data",  a_if.rd_data,  128'h000000A0_000000A1_000000A2_000000A3);
    pop_a();
    check("a_pop_empty",   a_if.empty,   1);
    check("a_pop_rd_data", a_if.rd_data, 0);

    // Fill 3 entries, then a 13th word overflows
    for (int e = 0; e < 3; e++)
      for (int w = 0; w < 4; w++)
        wa(32'hC00 + 32'(e * 16 + w));
    check("fill_full",  a_if.full,  1);
    check("fill_count", a_if.count, 3);
    check("fill_ovf0",  a_if.overflow, 0);
    wa(32'hDEAD);
    check("ovf_flag",  a_if.overflow, 1);
    check("ovf_count", a_if.count,    3);
    check("ovf_full",  a_if.full,     1);
    check("drain0", a_if.rd_data, 128'h00000C00_00000C01_00000C02_00000C03);
    pop_a();
    check("drain1", a_if.rd_data, 128'h00000C10_00000C11_00000C12_00000C13);
    pop_a();
    check("drain2", a_if.rd_data, 128'h00000C20_00000C21_00000C22_00000C23);
    pop_a();
    check("drain_empty", a_if.empty, 1);
    a_if.clear_err = 1'b1;
    tick();
    a_if.clear_err = 1'b0;
    check("clear_err", a_if.overflow, 0);

    // Partial entry, flush (with WE in the same cycle), then B0..B3
    wa(32'h11); wa(32'h22);
    a_if.flush = 1'b1; a_if.HWDATA = 32'h99; a_if.WE = 1'b1;
    tick();
    a_if.flush = 1'b0; a_if.WE = 1'b0;
    check("flush_ovf",   a_if.overflow, 0);
    check("flush_count", a_if.count,    0);
    wa(32'hB0); wa(32'hB1); wa(32'hB2); wa(32'hB3);
    check("flush_entry_count", a_if.count,   1);
    check("flush_entry_data",  a_if.rd_data, 128'h000000B0_000000B1_000000B2_000000B3);
    check("flush_entry_ovf",   a_if.overflow, 0);
    pop_a();

    // Full FIFO; 4th entry's final word arrives together with rd_ready
    for (int e = 0; e < 3; e++)
      for (int w = 0; w < 4; w++)
        wa(32'h400 + 32'(e * 16 + w));
    check("f2_full", a_if.full, 1);
    wa(32'hE0); wa(32'hE1); wa(32'hE2);
    a_if.HWDATA = 32'hE3; a_if.WE = 1'b1; a_if.rd_ready = 1'b1;
    tick();
    a_if.WE = 1'b0; a_if.rd_ready = 1'b0;
    check("popdrop_count", a_if.count,    2);
    check("popdrop_ovf",   a_if.overflow, 1);
    check("popdrop_full",  a_if.full,     0);
    check("popdrop_head",  a_if.rd_data,  128'h00000410_00000411_00000412_00000413);
    a_if.clear_err = 1'b1;
    tick();
    a_if.clear_err = 1'b0;
    check("popdrop_clear", a_if.overflow, 0);
    for (int w = 0; w < 4; w++) wa(32'h430 + 32'(w));
    check("refill_count", a_if.count, 3);
    // Drop and clear in the same cycle: the drop wins
    a_if.HWDATA = 32'hEE; a_if.WE = 1'b1; a_if.clear_err = 1'b1;
    tick();
    a_if.WE = 1'b0; a_if.clear_err = 1'b0;
    check("set_beats_clear", a_if.overflow, 1);
    check("wrap_d0", a_if.rd_data, 128'h00000410_00000411_00000412_00000413);
    pop_a();
    check("wrap_d1", a_if.rd_data, 128'h00000420_00000421_00000422_00000423);
    pop_a();
    check("wrap_d2", a_if.rd_data, 128'h00000430_00000431_00000432_00000433);
    pop_a();
    check("wrap_empty", a_if.empty, 1);

    // Reset mid-entry, then a fresh entry
    wa(32'hF0); wa(32'hF1);
    n_rst_a = 1'b0;
    tick();
    n_rst_a = 1'b1;
    check("midrst_count", a_if.count, 0);
    check("midrst_ovf",   a_if.overflow, 0);
    wa(32'hD0); wa(32'hD1); wa(32'hD2); wa(32'hD3);
    check("midrst_entry_count", a_if.count,   1);
    check("midrst_entry_data",  a_if.rd_data, 128'h000000D0_000000D1_000000D2_000000D3);
    // Reset with a committed entry pending
    n_rst_a = 1'b0;
    tick();
    n_rst_a = 1'b1;
    check("rdrst_valid", a_if.rd_valid, 0);
    check("rdrst_data",  a_if.rd_data,  0);

    // DEPTH=5: stream 10 entries with rd_ready held high
    b_if.rd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int w = 0; w < 4; w++) begin
        b_if.HWDATA = 32'h5000 + 32'(k * 16 + w);
        b_if.WE     = 1'b1;
        tick();
      end
      check($sformatf("stream_valid_%0d", k), b_if.rd_valid, 1);
      check($sformatf("stream_data_%0d", k), b_if.rd_data,
            ent_seq(32'h5000 + 32'(k * 16)));
    end
    b_if.WE = 1'b0;
    tick();
    b_if.rd_ready = 1'b0;
    check("stream_end_empty", b_if.empty,    1);
    check("stream_end_count", b_if.count,    0);
    check("stream_end_ovf",   b_if.overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
